// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, packed flag struct, opcodes,
// and the occupancy encoding of the writeback skid buffer.
package alu_pkg;

    localparam int FLG_OVF  = 5;
    localparam int FLG_NEG  = 4;
    localparam int FLG_ZERO = 3;
    localparam int FLG_EQ   = 2;
    localparam int FLG_GT   = 1;
    localparam int FLG_LT   = 0;

    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
        logic eq;
        logic gt;
        logic lt;
    } alu_flags_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_CMP = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/wb_skid2.sv
// Two-entry FIFO-ordered valid/ready buffer over an opaque packed payload.
// Occupancy FSM:
//   state      | meaning
//   SKID_EMPTY | no entries, out_valid low
//   SKID_ONE   | head entry valid, tail free
//   SKID_FULL  | head and tail valid, in_ready low
// in_ready is a flop loaded from the next state, so out_ready never reaches
// it combinationally; out_payload comes straight from the head register.
module wb_skid2
    import alu_pkg::*;
#(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);

    skid_state_t r_state;
    skid_state_t w_next_state;
    logic        r_in_ready;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic        w_push;
    logic        w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = out_valid & out_ready;

    // State register plus registered ready derived from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != SKID_FULL);
        end
    end

    // Next-state logic; flush empties the buffer regardless of push/pop.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: if (w_push) w_next_state = SKID_ONE;
                SKID_ONE: begin
                    if (w_push && !w_pop)      w_next_state = SKID_FULL;
                    else if (w_pop && !w_push) w_next_state = SKID_EMPTY;
                end
                SKID_FULL:  if (w_pop) w_next_state = SKID_ONE;
                default:    w_next_state = SKID_EMPTY;
            endcase
        end
    end

    // Output decode from registered state and head entry.
    always_comb begin
        out_valid   = (r_state != SKID_EMPTY);
        in_ready    = r_in_ready;
        out_payload = r_head;
    end

    // Entry storage: head is what the consumer sees, tail backs it up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!flush) begin
            case (r_state)
                SKID_EMPTY: if (w_push) r_head <= in_payload;
                SKID_ONE: begin
                    if (w_push && w_pop) r_head <= in_payload;
                    else if (w_push)     r_tail <= in_payload;
                end
                SKID_FULL:  if (w_pop) r_head <= r_tail;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback/status stage: buffers results toward the register file and
// keeps the architectural flags plus a sticky overflow for branch logic.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [5:0]        in_flags,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_setf,
    input  logic              flush,
    input  logic              clr_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [5:0]        flags_q,
    output logic              ovf_sticky
);

    localparam int PAY_W = DATA_W + REG_AW + 1;

    logic [PAY_W-1:0] w_in_payload;
    logic [PAY_W-1:0] w_out_payload;
    logic             w_push;
    alu_flags_t       r_flags;
    logic             r_sticky;

    assign w_in_payload = {in_result, in_rd, in_we};
    assign {out_data, out_rd, out_we} = w_out_payload;

    wb_skid2 #(.W(PAY_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (w_in_payload),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (w_out_payload)
    );

    // The instruction has executed once accepted, so flush does not block this.
    assign w_push = in_valid & in_ready;

    // Flags follow accepted flag-setting instructions; sticky set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags  <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push && in_setf) r_flags <= alu_flags_t'(in_flags);
            if (w_push && in_setf && in_flags[FLG_OVF]) r_sticky <= 1'b1;
            else if (clr_sticky)                        r_sticky <= 1'b0;
        end
    end

    assign flags_q    = r_flags;
    assign ovf_sticky = r_sticky;

endmodule
